mul_rs: RTL and testbench

Reservation station for the pipelined integer multiplier in the Tomasulo core. It accepts multiply instructions from the issue stage and snoops the CDB for pending operands. It dispatches ready entries into the multiplier pipeline and tracks each in-flight tag through a delay line matched to the multiplier latency. Finished products are buffered and presented to the CDB arbiter with a valid/ack handshake.

---
 rtl/mul_rs_pkg.sv | 16 +
 rtl/mul_rs_tag_delay.sv | 37 +++
 rtl/mul_rs.sv | 236 +++++++++++++++++++++++
 tb/tb_mul_rs.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rs_pkg.sv
// Shared types and default sizing for the multiplier reservation station.
package mul_rs_pkg;

  localparam int unsigned RS_TAG_W = 4;
  localparam int unsigned MUL_LAT  = 6;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_WAIT  = 3'd1,
    S_READY = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } rs_state_e;

endpackage

// File: rtl/mul_rs_tag_delay.sv
// Valid+tag shift register that follows each dispatched op through the
// multiplier so the tag emerges in the same cycle as its product.
module mul_rs_tag_delay #(
  parameter int unsigned LAT   = 6,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q [LAT];
  logic [TAG_W-1:0] tag_q   [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign tag_o   = tag_q[LAT-1];

endmodule

// File: rtl/mul_rs.sv
// Reservation station for the pipelined integer multiplier: issue, CDB snoop,
// in-order-of-readiness dispatch, and a result FIFO toward the CDB arbiter.
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int unsigned ENTRIES  = 3,
  parameter int unsigned TAG_W    = RS_TAG_W,
  parameter int unsigned BASE_TAG = 4,
  parameter int unsigned LAT      = MUL_LAT
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              mul_en,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_result,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic [DATA_W-1:0] done_data,
  input  logic              done_ack
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

  rs_state_e         state_q [ENTRIES];
  rs_state_e         state_d [ENTRIES];
  logic [TAG_W-1:0]  qj_q [ENTRIES];
  logic [TAG_W-1:0]  qj_d [ENTRIES];
  logic [TAG_W-1:0]  qk_q [ENTRIES];
  logic [TAG_W-1:0]  qk_d [ENTRIES];
  logic [DATA_W-1:0] vj_q [ENTRIES];
  logic [DATA_W-1:0] vj_d [ENTRIES];
  logic [DATA_W-1:0] vk_q [ENTRIES];
  logic [DATA_W-1:0] vk_d [ENTRIES];

  logic [TAG_W-1:0]  fifo_tag_q  [ENTRIES];
  logic [TAG_W-1:0]  fifo_tag_d  [ENTRIES];
  logic [DATA_W-1:0] fifo_data_q [ENTRIES];
  logic [DATA_W-1:0] fifo_data_d [ENTRIES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_valid_q, done_valid_d;

  logic              mul_en_q, mul_en_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [TAG_W-1:0]  disp_tag_q, disp_tag_d;

  logic              issue_found, disp_found;
  logic [IDX_W-1:0]  issue_idx, disp_idx;
  logic              dl_valid;
  logic [TAG_W-1:0]  dl_tag;
  logic              push, pop;
  logic [CNT_W-1:0]  wr_idx;

  function automatic logic [TAG_W-1:0] tag_of(input int unsigned idx);
    return TAG_W'(BASE_TAG + idx);
  endfunction

  // Lowest-index EMPTY entry takes the next issue; lowest-index READY dispatches.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!issue_found && state_q[i] == S_EMPTY) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!disp_found && state_q[i] == S_READY) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = issue_found;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(issue_idx);

  mul_rs_tag_delay #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (nRST),
    .valid_i (mul_en_q),
    .tag_i   (disp_tag_q),
    .valid_o (dl_valid),
    .tag_o   (dl_tag)
  );

  // Entry FSMs, dispatch register and result FIFO next-state.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i]     = state_q[i];
      qj_d[i]        = qj_q[i];
      qk_d[i]        = qk_q[i];
      vj_d[i]        = vj_q[i];
      vk_d[i]        = vk_q[i];
      fifo_tag_d[i]  = fifo_tag_q[i];
      fifo_data_d[i] = fifo_data_q[i];
    end
    mul_en_d   = 1'b0;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    disp_tag_d = disp_tag_q;
    pop        = done_valid_q && done_ack;
    push       = dl_valid;
    wr_idx     = pop ? cnt_q - CNT_W'(1) : cnt_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);

    for (int i = 0; i < ENTRIES; i++) begin
      case (state_q[i])
        S_EMPTY: begin
          if (issue_valid && issue_found && issue_idx == IDX_W'(i)) begin
            qj_d[i] = issue_qj;
            vj_d[i] = issue_vj;
            qk_d[i] = issue_qk;
            vk_d[i] = issue_vk;
            // A broadcast in the issue cycle would otherwise be missed.
            if (cdb_valid && issue_qj != '0 && issue_qj == cdb_tag) begin
              qj_d[i] = '0;
              vj_d[i] = cdb_data;
            end
            if (cdb_valid && issue_qk != '0 && issue_qk == cdb_tag) begin
              qk_d[i] = '0;
              vk_d[i] = cdb_data;
            end
            state_d[i] = (qj_d[i] == '0 && qk_d[i] == '0) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cdb_valid && qj_q[i] != '0 && qj_q[i] == cdb_tag) begin
            qj_d[i] = '0;
            vj_d[i] = cdb_data;
          end
          if (cdb_valid && qk_q[i] != '0 && qk_q[i] == cdb_tag) begin
            qk_d[i] = '0;
            vk_d[i] = cdb_data;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) state_d[i] = S_READY;
        end
        S_READY: begin
          if (disp_found && disp_idx == IDX_W'(i)) begin
            mul_en_d   = 1'b1;
            mul_a_d    = vj_q[i];
            mul_b_d    = vk_q[i];
            disp_tag_d = tag_of(i);
            state_d[i] = S_EXEC;
          end
        end
        S_EXEC: begin
          if (push && dl_tag == tag_of(i)) state_d[i] = S_DONE;
        end
        S_DONE: begin
          if (pop && fifo_tag_q[0] == tag_of(i)) state_d[i] = S_EMPTY;
        end
        default: state_d[i] = S_EMPTY;
      endcase
    end

    // Shifting FIFO keeps the head in slot 0 so done_* come straight from flops.
    if (pop) begin
      for (int i = 0; i + 1 < ENTRIES; i++) begin
        fifo_tag_d[i]  = fifo_tag_q[i+1];
        fifo_data_d[i] = fifo_data_q[i+1];
      end
      fifo_tag_d[ENTRIES-1]  = '0;
      fifo_data_d[ENTRIES-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          fifo_tag_d[i]  = dl_tag;
          fifo_data_d[i] = mul_result;
        end
      end
    end
    done_valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i]     <= S_EMPTY;
        qj_q[i]        <= '0;
        qk_q[i]        <= '0;
        vj_q[i]        <= '0;
        vk_q[i]        <= '0;
        fifo_tag_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      mul_en_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      disp_tag_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i]     <= state_d[i];
        qj_q[i]        <= qj_d[i];
        qk_q[i]        <= qk_d[i];
        vj_q[i]        <= vj_d[i];
        vk_q[i]        <= vk_d[i];
        fifo_tag_q[i]  <= fifo_tag_d[i];
        fifo_data_q[i] <= fifo_data_d[i];
      end
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      mul_en_q     <= mul_en_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      disp_tag_q   <= disp_tag_d;
    end
  end

  assign mul_en     = mul_en_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign done_valid = done_valid_q;
  assign done_tag   = fifo_tag_q[0];
  assign done_data  = fifo_data_q[0];

endmodule

// File: tb/tb_mul_rs.sv
// Scoreboard bench for mul_rs with a LAT-stage multiplier model.
module tb_mul_rs;

  localparam int unsigned LAT = 6;

  logic        clk;
  logic        nRST;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic [3:0]  issue_qj, issue_qk;
  logic [31:0] issue_vj, issue_vk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        mul_en;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        done_valid;
  logic [3:0]  done_tag;
  logic [31:0] done_data;
  logic        done_ack;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mul_rs #(
    .ENTRIES  (3),
    .TAG_W    (4),
    .BASE_TAG (4),
    .LAT      (LAT)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .mul_en      (mul_en),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_result  (mul_result),
    .done_valid  (done_valid),
    .done_tag    (done_tag),
    .done_data   (done_data),
    .done_ack    (done_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier: samples the registered operands every edge, product LAT edges later.
  logic [31:0] mpipe [LAT];
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mul_a * mul_b;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_result = mpipe[LAT-1];

  // Monitor: every accepted result is compared with the scoreboard head.
  always @(negedge clk) begin
    if (nRST && done_valid && done_ack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected act tag=%0d data=%h req none", done_tag, done_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (done_tag !== e.tag || done_data !== e.data) begin
          n_err++;
          $display("FAIL result act tag=%0d data=%h req tag=%0d data=%h",
                   done_tag, done_data, e.tag, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic do_issue(input logic [3:0] exp_tag, input logic [3:0] qj, input logic [31:0] vj,
                          input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] exp_data);
    exp_t e;
    issue_valid = 1'b1;
    issue_qj = qj;
    issue_vj = vj;
    issue_qk = qk;
    issue_vk = vk;
    chk("issue_ready", 32'(issue_ready), 32'd1);
    chk("issue_tag", 32'(issue_tag), 32'(exp_tag));
    e.tag = exp_tag;
    e.data = exp_data;
    exp_q.push_back(e);
    tick();
    issue_valid = 1'b0;
    issue_qj = '0;
    issue_qk = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_issue_ready"}, 32'(issue_ready), 32'd1);
    chk({pfx, "_issue_tag"}, 32'(issue_tag), 32'd4);
    chk({pfx, "_mul_en"}, 32'(mul_en), 32'd0);
    chk({pfx, "_mul_a"}, mul_a, 32'd0);
    chk({pfx, "_mul_b"}, mul_b, 32'd0);
    chk({pfx, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({pfx, "_done_tag"}, 32'(done_tag), 32'd0);
    chk({pfx, "_done_data"}, done_data, 32'd0);
  endtask

  task automatic quiet_window(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_valid !== 1'b0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  initial begin
    int   edges;
    logic busy;
    nRST = 1'b0;
    issue_valid = 1'b0;
    issue_qj = '0;
    issue_qk = '0;
    issue_vj = '0;
    issue_vk = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    done_ack = 1'b1;

    // Reset state; ack held high while nothing is valid must be harmless.
    #3;
    chk_reset_vals("rst");
    tick();
    tick();
    nRST = 1'b1;
    quiet_window("rst_quiet");

    // 3*5 with both operands present; result 8 edges after issue.
    do_issue(4'd4, 4'd0, 32'd3, 4'd0, 32'd5, 32'd15);
    chk("t1_no_early_dispatch", 32'(mul_en), 32'd0);
    tick();
    chk("t1_mul_en", 32'(mul_en), 32'd1);
    chk("t1_mul_a", mul_a, 32'd3);
    chk("t1_mul_b", mul_b, 32'd5);
    edges = 1;
    while (!done_valid && edges < 40) begin
      tick();
      edges++;
    end
    chk("t1_done_latency", 32'(edges), 32'd8);
    drain("t1_drain");

    // Operand j waits on tag 7; the CDB supplies 0xFFFFFFFF later.
    do_issue(4'd4, 4'd7, 32'h0000_1234, 4'd0, 32'd2, 32'hFFFF_FFFE);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mul_en !== 1'b0) busy = 1'b1;
      tick();
    end
    chk("t2_wait_no_dispatch", 32'(busy), 32'd0);
    cdb_valid = 1'b1;
    cdb_tag = 4'd7;
    cdb_data = 32'hFFFF_FFFF;
    tick();
    cdb_valid = 1'b0;
    chk("t2_dispatch_not_same_edge", 32'(mul_en), 32'd0);
    tick();
    chk("t2_mul_en", 32'(mul_en), 32'd1);
    chk("t2_mul_a", mul_a, 32'hFFFF_FFFF);
    drain("t2_drain");

    // CDB broadcast in the issue cycle is captured directly.
    cdb_valid = 1'b1;
    cdb_tag = 4'd7;
    cdb_data = 32'd9;
    do_issue(4'd4, 4'd7, 32'd0, 4'd0, 32'd4, 32'd36);
    cdb_valid = 1'b0;
    tick();
    chk("t3_mul_en", 32'(mul_en), 32'd1);
    chk("t3_mul_a", mul_a, 32'd9);
    chk("t3_mul_b", mul_b, 32'd4);
    drain("t3_drain");

    // Fill all three entries with ack held low; results wait in order.
    done_ack = 1'b0;
    do_issue(4'd4, 4'd0, 32'd2, 4'd0, 32'd3, 32'd6);
    do_issue(4'd5, 4'd0, 32'h0001_0000, 4'd0, 32'h0001_0000, 32'd0);
    do_issue(4'd6, 4'd0, 32'd7, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    chk("t4_full_not_ready", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_still_full", 32'(issue_ready), 32'd0);
    chk("t4_head_valid", 32'(done_valid), 32'd1);
    chk("t4_head_tag", 32'(done_tag), 32'd4);
    chk("t4_head_data", done_data, 32'd6);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("t4_freed_ready", 32'(issue_ready), 32'd1);
    chk("t4_freed_tag", 32'(issue_tag), 32'd4);
    chk("t4_next_valid", 32'(done_valid), 32'd1);
    chk("t4_next_tag", 32'(done_tag), 32'd5);
    chk("t4_next_data", done_data, 32'd0);
    done_ack = 1'b1;
    drain("t4_drain");

    // Reset with two products in flight flushes everything.
    do_issue(4'd4, 4'd0, 32'd11, 4'd0, 32'd13, 32'd143);
    do_issue(4'd5, 4'd0, 32'd100, 4'd0, 32'd200, 32'd20000);
    tick();
    tick();
    tick();
    nRST = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("mid");
    tick();
    tick();
    nRST = 1'b1;
    quiet_window("mid_quiet");

    // Station still works after the flush.
    do_issue(4'd4, 4'd0, 32'h0000_FFFF, 4'd0, 32'h0000_FFFF, 32'hFFFE_0001);
    drain("t5_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
